// File: rtl/hash_ti_verifier_pkg.sv
// Shared constants and the verifier state encoding for the Ascon-Hash verifier slice.
// Latency: none (package only).
// Backpressure: none (package only).
package ascon_pkg;

  // Ascon-Hash absorbs and squeezes 64 bits per permutation, which is also the
  // natural digest compare chunk.
  localparam int ASCON_RATE = 64;

  // Verifier sequencing states. Encodings are fixed so that waveform dumps
  // from different builds read the same.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LAUNCH  = 3'd1,
    ST_WAIT    = 3'd2,
    ST_COMPARE = 3'd3,
    ST_RELEASE = 3'd4,
    ST_DRAIN   = 3'd5,
    ST_RESULT  = 3'd6
  } ver_state_e;

endpackage

// File: rtl/hash_ti_verifier_if.sv
// Host-side request/result bundle of the hash verifier.
// Latency: none (wiring only).
// Backpressure: msg_valid/msg_ready for requests, res_valid/res_ready for results.
//   master: host side (drives the request and res_ready)
//   slave : verifier side (drives msg_ready and the result)
interface hash_ti_verifier_if #(
  parameter int Y = 40,
  parameter int L = 256
);
  logic         msg_valid;
  logic         msg_ready;
  logic [Y-1:0] message;
  logic [Y-1:0] rnd_m1;
  logic [Y-1:0] rnd_m2;
  logic [L-1:0] expected;
  logic         res_valid;
  logic         res_ready;
  logic         res_match;
  logic         res_error;

  modport master (
    output msg_valid, message, rnd_m1, rnd_m2, expected, res_ready,
    input  msg_ready, res_valid, res_match, res_error
  );

  modport slave (
    input  msg_valid, message, rnd_m1, rnd_m2, expected, res_ready,
    output msg_ready, res_valid, res_match, res_error
  );
endinterface

// File: rtl/hash_ti_verifier_tag_compare.sv
// Chunked digest comparator: selects chunk idx of both vectors and ORs any difference into a sticky flag.
// Latency: diff reflects a chunk one cycle after en; one chunk per enabled cycle.
// Backpressure: none; the caller sequences idx/en and clears with clr.
//   clk, rst   clock and synchronous active-high reset
//   clr, en    clear the sticky flag / accumulate chunk idx
//   idx        chunk index, 0 = most significant chunk
//   digest     digest from the core, expected: digest from the host
//   diff       sticky: 1 once any compared chunk differed
module hash_tag_compare #(
  parameter int L     = 256,
  parameter int CMP_W = 64,
  parameter int IDX_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [IDX_W-1:0] idx,
  input  logic [L-1:0]     digest,
  input  logic [L-1:0]     expected,
  output logic             diff
);
  localparam int NCHUNK = L / CMP_W;

  logic [CMP_W-1:0] dig_chunk;
  logic [CMP_W-1:0] exp_chunk;

  // Full mux over all chunks: every compare cycle does the same work
  // regardless of data, so the verdict time does not leak where vectors differ.
  always_comb begin
    dig_chunk = '0;
    exp_chunk = '0;
    for (int i = 0; i < NCHUNK; i++) begin
      if (idx == IDX_W'(i)) begin
        dig_chunk = digest[L-1-i*CMP_W -: CMP_W];
        exp_chunk = expected[L-1-i*CMP_W -: CMP_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      diff <= 1'b0;
    end else if (en) begin
      diff <= diff | (|(dig_chunk ^ exp_chunk));
    end
  end
endmodule

// File: rtl/hash_ti_verifier.sv
// Host-side initiator/checker for the 3-share masked Ascon-Hash core: launch, wait, constant-time compare, release.
// Latency: accept edge to res_valid = 1 + core latency + 1 + L/CMP_W + 1 + 2 cycles; timeout after TIMEOUT+1 WAIT cycles.
// Backpressure: msg_ready only in IDLE; result held in RESULT until res_ready.
//   clk, rst      clock and synchronous active-high reset (shared with the core)
//   host          request (message, masks, expected digest) and result (match/error)
//   core_start    single-cycle start pulse (launch, then release)
//   core_message, core_rand_m1, core_rand_m2   registered operands for the core
//   core_ready    core done level, core_hash: recombined digest valid while ready
module hash_ti_verifier
  import ascon_pkg::*;
#(
  parameter int Y       = 40,
  parameter int L       = 256,
  parameter int CMP_W   = ASCON_RATE,
  parameter int TIMEOUT = 1023
) (
  input  logic                clk,
  input  logic                rst,
  hash_ti_verifier_if.slave   host,
  output logic                core_start,
  output logic [Y-1:0]        core_message,
  output logic [Y-1:0]        core_rand_m1,
  output logic [Y-1:0]        core_rand_m2,
  input  logic                core_ready,
  input  logic [L-1:0]        core_hash
);
  localparam int NCHUNK = L / CMP_W;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int TO_W   = $clog2(TIMEOUT + 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NCHUNK - 1);
  localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(TIMEOUT);

  ver_state_e state_q, state_d;

  logic [Y-1:0]     msg_q, m1_q, m2_q;
  logic [L-1:0]     exp_q, digest_q;
  logic [IDX_W-1:0] idx_q;
  logic [TO_W-1:0]  to_cnt_q;
  logic             match_q, error_q;
  logic             diff;

  logic accept, wait_done, wait_expire, cmp_en, drain_done, res_take, cmp_clr;

  always_comb begin
    state_d     = state_q;
    accept      = 1'b0;
    wait_done   = 1'b0;
    wait_expire = 1'b0;
    cmp_en      = 1'b0;
    drain_done  = 1'b0;
    res_take    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (host.msg_valid) begin
          accept  = 1'b1;
          state_d = ST_LAUNCH;
        end
      end
      ST_LAUNCH: state_d = ST_WAIT;
      ST_WAIT: begin
        if (core_ready) begin
          wait_done = 1'b1;
          state_d   = ST_COMPARE;
        end else if (to_cnt_q == TO_MAX) begin
          // The core is left running; only rst brings it back.
          wait_expire = 1'b1;
          state_d     = ST_RESULT;
        end
      end
      ST_COMPARE: begin
        cmp_en = 1'b1;
        if (idx_q == IDX_LAST) state_d = ST_RELEASE;
      end
      ST_RELEASE: state_d = ST_DRAIN;
      ST_DRAIN: begin
        // Wait for the core to leave DONE so the next launch is seen as a fresh start.
        if (!core_ready) begin
          drain_done = 1'b1;
          state_d    = ST_RESULT;
        end
      end
      ST_RESULT: begin
        if (host.res_ready) begin
          res_take = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign cmp_clr = wait_done | res_take;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      msg_q    <= '0;
      m1_q     <= '0;
      m2_q     <= '0;
      exp_q    <= '0;
      digest_q <= '0;
      idx_q    <= '0;
      to_cnt_q <= '0;
      match_q  <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        msg_q <= host.message;
        m1_q  <= host.rnd_m1;
        m2_q  <= host.rnd_m2;
        exp_q <= host.expected;
      end
      if (state_q == ST_LAUNCH) begin
        to_cnt_q <= '0;
      end else if (state_q == ST_WAIT && !core_ready && to_cnt_q != TO_MAX) begin
        to_cnt_q <= to_cnt_q + 1'b1;
      end
      if (wait_done) begin
        digest_q <= core_hash;
        idx_q    <= '0;
      end
      if (cmp_en) idx_q <= idx_q + 1'b1;
      if (wait_expire) begin
        error_q <= 1'b1;
        match_q <= 1'b0;
      end
      if (drain_done) match_q <= ~diff;
      if (res_take) begin
        // Scrub the request so masks and digests do not linger between requests.
        msg_q    <= '0;
        m1_q     <= '0;
        m2_q     <= '0;
        exp_q    <= '0;
        digest_q <= '0;
        idx_q    <= '0;
        to_cnt_q <= '0;
        match_q  <= 1'b0;
        error_q  <= 1'b0;
      end
    end
  end

  hash_tag_compare #(
    .L     (L),
    .CMP_W (CMP_W),
    .IDX_W (IDX_W)
  ) u_cmp (
    .clk      (clk),
    .rst      (rst),
    .clr      (cmp_clr),
    .en       (cmp_en),
    .idx      (idx_q),
    .digest   (digest_q),
    .expected (exp_q),
    .diff     (diff)
  );

  // Launch and release are separated by at least WAIT and COMPARE, so the
  // start pulse can never be high on two consecutive cycles.
  assign core_start     = (state_q == ST_LAUNCH) || (state_q == ST_RELEASE);
  assign core_message   = msg_q;
  assign core_rand_m1   = m1_q;
  assign core_rand_m2   = m2_q;
  assign host.msg_ready = (state_q == ST_IDLE);
  assign host.res_valid = (state_q == ST_RESULT);
  assign host.res_match = match_q;
  assign host.res_error = error_q;
endmodule

// File: tb/tb_hash_ti_verifier.sv
// Directed bench for hash_ti_verifier with a behavioural core stub.
// Latency: stub readies 30 cycles after launch, drops ready 2 cycles after release.
// Backpressure: host result acceptance is held off in one step.
module tb_hash_ti_verifier;
  localparam int Y   = 40;
  localparam int L   = 256;
  localparam int TMO = 100;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hash_ti_verifier_if #(.Y(Y), .L(L)) hif();

  logic         core_start;
  logic [Y-1:0] core_message, core_rand_m1, core_rand_m2;
  logic         core_ready;
  logic [L-1:0] core_hash;

  hash_ti_verifier #(.Y(Y), .L(L), .CMP_W(64), .TIMEOUT(TMO)) dut (
    .clk          (clk),
    .rst          (rst),
    .host         (hif),
    .core_start   (core_start),
    .core_message (core_message),
    .core_rand_m1 (core_rand_m1),
    .core_rand_m2 (core_rand_m2),
    .core_ready   (core_ready),
    .core_hash    (core_hash)
  );

  // Core stub
  logic         never_ready = 1'b0;
  logic         drop_pend;
  int           stub_cnt;
  logic [L-1:0] pat = {32{8'hA5}};
  assign core_hash = pat;

  always @(posedge clk) begin
    if (rst) begin
      core_ready <= 1'b0;
      stub_cnt   <= 0;
      drop_pend  <= 1'b0;
    end else begin
      drop_pend <= core_start && core_ready;
      if (drop_pend) core_ready <= 1'b0;
      if (core_start && !core_ready && !never_ready) stub_cnt <= 30;
      else if (stub_cnt == 1) begin
        core_ready <= 1'b1;
        stub_cnt   <= 0;
      end else if (stub_cnt > 1) stub_cnt <= stub_cnt - 1;
    end
  end

  // Start-pulse monitor
  int   starts = 0, launches = 0, releases = 0, consec = 0;
  logic start_prev = 1'b0;
  always @(posedge clk) begin
    if (core_start) begin
      starts = starts + 1;
      if (core_ready) releases = releases + 1;
      else launches = launches + 1;
      if (start_prev) consec = consec + 1;
    end
    start_prev = core_start;
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [Y-1:0] m, input logic [Y-1:0] r1,
                      input logic [Y-1:0] r2, input logic [L-1:0] e);
    hif.msg_valid = 1'b1;
    hif.message   = m;
    hif.rnd_m1    = r1;
    hif.rnd_m2    = r2;
    hif.expected  = e;
    @(posedge clk);
    @(negedge clk);
    hif.msg_valid = 1'b0;
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!hif.res_valid && lat < 400);
  endtask

  task automatic accept_result();
    hif.res_ready = 1'b1;
    @(negedge clk);
    hif.res_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1, "watchdog");
  end

  int   lat, s0, l0, r0;
  logic stable;

  initial begin
    rst           = 1'b1;
    hif.msg_valid = 1'b0;
    hif.res_ready = 1'b0;
    hif.message   = '0;
    hif.rnd_m1    = '0;
    hif.rnd_m2    = '0;
    hif.expected  = '0;
    repeat (3) @(negedge clk);

    // Reset values
    check("rst_msg_ready", 256'(hif.msg_ready), 256'd1);
    check("rst_res_valid", 256'(hif.res_valid), 256'd0);
    check("rst_res_match", 256'(hif.res_match), 256'd0);
    check("rst_res_error", 256'(hif.res_error), 256'd0);
    check("rst_core_start", 256'(core_start), 256'd0);
    check("rst_core_message", 256'(core_message), 256'd0);
    check("rst_core_rand", 256'({core_rand_m1, core_rand_m2}), 256'd0);
    rst = 1'b0;
    @(negedge clk);

    // T1 match
    s0 = starts;
    send(40'h0123456789, 40'h1111111111, 40'h2222222222, pat);
    check("t1_launch_pulse", 256'(core_start), 256'd1);
    check("t1_msg_ready_busy", 256'(hif.msg_ready), 256'd0);
    check("t1_core_message", 256'(core_message), 256'h0123456789);
    check("t1_core_masks", 256'({core_rand_m1, core_rand_m2}), 256'h11111111112222222222);
    wait_result(lat);
    check("t1_latency", 256'(lat), 256'd39);
    check("t1_match", 256'(hif.res_match), 256'd1);
    check("t1_error", 256'(hif.res_error), 256'd0);
    check("t1_start_pulses", 256'(starts - s0), 256'd2);
    accept_result();
    check("t1_idle_ready", 256'(hif.msg_ready), 256'd1);
    check("t1_idle_valid", 256'(hif.res_valid), 256'd0);
    check("t1_scrubbed", 256'(core_message), 256'd0);

    // T2 last-chunk mismatch (bit 0)
    send(40'hA5A5000001, 40'h0F0F0F0F0F, 40'h3C3C3C3C3C, pat ^ 256'd1);
    wait_result(lat);
    check("t2_latency", 256'(lat), 256'd39);
    check("t2_match", 256'(hif.res_match), 256'd0);
    check("t2_error", 256'(hif.res_error), 256'd0);

    // T4 result backpressure on the T2 result, with a competing request
    s0 = starts;
    hif.msg_valid = 1'b1;
    hif.message   = 40'hDEADBEEF00;
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (hif.res_valid !== 1'b1 || hif.res_match !== 1'b0 || hif.res_error !== 1'b0 ||
          hif.msg_ready !== 1'b0 || core_message !== 40'hA5A5000001)
        stable = 1'b0;
    end
    check("t4_stable", 256'(stable), 256'd1);
    check("t4_no_start", 256'(starts - s0), 256'd0);
    hif.msg_valid = 1'b0;
    accept_result();

    // T3 timeout
    never_ready = 1'b1;
    s0 = starts;
    send(40'h1122334455, 40'h5555555555, 40'hAAAAAAAAAA, pat);
    wait_result(lat);
    check("t3_latency", 256'(lat), 256'd102);
    check("t3_error", 256'(hif.res_error), 256'd1);
    check("t3_match", 256'(hif.res_match), 256'd0);
    check("t3_start_pulses", 256'(starts - s0), 256'd1);
    accept_result();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    never_ready = 1'b0;
    @(negedge clk);

    // T5 reset during COMPARE
    send(40'h0123456789, 40'h1111111111, 40'h2222222222, pat);
    repeat (33) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("t5_msg_ready", 256'(hif.msg_ready), 256'd1);
    check("t5_res_valid", 256'(hif.res_valid), 256'd0);
    check("t5_core_start", 256'(core_start), 256'd0);
    check("t5_core_message", 256'(core_message), 256'd0);
    check("t5_res_flags", 256'({hif.res_match, hif.res_error}), 256'd0);
    rst = 1'b0;
    @(negedge clk);
    send(40'h0A0B0C0D0E, 40'h1234512345, 40'h5432154321, pat);
    wait_result(lat);
    check("t5_latency", 256'(lat), 256'd39);
    check("t5_match", 256'(hif.res_match), 256'd1);
    accept_result();

    // T6 back-to-back requests
    s0 = starts;
    l0 = launches;
    r0 = releases;
    send(40'h0000000001, 40'h0000000002, 40'h0000000003, pat);
    wait_result(lat);
    check("t6a_latency", 256'(lat), 256'd39);
    check("t6a_match", 256'(hif.res_match), 256'd1);
    accept_result();
    send(40'h0000000004, 40'h0000000005, 40'h0000000006, pat ^ {1'b1, 255'd0});
    wait_result(lat);
    check("t6b_latency", 256'(lat), 256'd39);
    check("t6b_match", 256'(hif.res_match), 256'd0);
    accept_result();
    repeat (3) @(negedge clk);
    check("t6_start_pulses", 256'(starts - s0), 256'd4);
    check("t6_launches_ready_low", 256'(launches - l0), 256'd2);
    check("t6_releases_ready_high", 256'(releases - r0), 256'd2);
    check("start_never_consecutive", 256'(consec), 256'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
